wide_word_serializer: RTL

//  Downstream consumer of the 4096-bit staging queue. Accepts one IN_W-bit word per

---
 rtl/wide_word_serializer.sv | 91 +++++++++
 1 files changed

// File: rtl/wide_word_serializer.sv
// Wide-to-narrow serializer: takes one IN_W-bit word per handshake and replays it
// as IN_W/OUT_W registered beats, LSB slice first, with zero-bubble word chaining.
module wide_word_serializer #(
  parameter int unsigned IN_W  = 4096,
  parameter int unsigned OUT_W = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IN_W-1:0]  io_enq_bits,
  input  logic             io_enq_valid,
  output logic             io_enq_ready,
  output logic [OUT_W-1:0] io_deq_bits,
  output logic             io_deq_valid,
  output logic             io_deq_last,
  input  logic             io_deq_ready
);

  localparam int unsigned BEATS = IN_W / OUT_W;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_t;

  typedef logic [BEATS-1:0][OUT_W-1:0] word_t;

  state_t           state_q, state_d;
  word_t            word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic full;
  logic deq_fire;
  logic enq_fire;

  assign full         = (state_q == BUSY);
  assign io_deq_valid = full;
  assign io_deq_last  = full && (cnt_q == LAST_CNT);
  assign io_deq_bits  = word_q[cnt_q];
  // A new word may enter on the same cycle the last beat of the current one leaves.
  assign io_enq_ready = !full || (io_deq_ready && io_deq_last);
  assign deq_fire     = full && io_deq_ready;
  assign enq_fire     = io_enq_valid && io_enq_ready;

  // State register and beat datapath
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: beat advance first, a word load overrides it
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY: begin
        if (enq_fire) begin
          word_d  = io_enq_bits;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (deq_fire) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = EMPTY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (enq_fire) begin
          word_d  = io_enq_bits;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule
